bmsce_serial_comparator: RTL and testbench

Parametrised, sequential magnitude comparator: the multi-bit, signed-capable successor to the team's 2-bit combinational gt/eq/lt comparator. It captures two WIDTH-bit operands on a start pulse and compares them MSB-first, DIGIT bits per enabled cycle, exiting early at the first differing digit. It reports registered gt/eq/lt with a one-cycle done pulse and keeps a completed-comparison count. It sits behind the tile wrapper, fed from ui_in/uio_in, with results driven onto uo_out.

---
 rtl/bmsce_serial_comparator_if.sv | 27 ++
 rtl/bmsce_serial_comparator.sv | 116 +++++++++++
 tb/tb_bmsce_serial_comparator.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bmsce_serial_comparator_if.sv
// Operand/result bundle for the serial magnitude comparator.
// The master side supplies operands and control; the slave side is the comparator.
interface bmsce_serial_comparator_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [7:0]       cmp_count;

    modport master (
        output ena, start, signed_mode, a, b,
        input  busy, done, gt, eq, lt, cmp_count
    );

    modport slave (
        input  ena, start, signed_mode, a, b,
        output busy, done, gt, eq, lt, cmp_count
    );
endinterface

// File: rtl/bmsce_serial_comparator.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per enabled cycle,
// exiting at the first differing digit; signed operands use offset-binary.
module bmsce_serial_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    bmsce_serial_comparator_if.slave      bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] sa_reg,     sa_next;
    logic [WIDTH-1:0] sb_reg,     sb_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic             gt_reg,     gt_next;
    logic             eq_reg,     eq_next;
    logic             lt_reg,     lt_next;
    logic [7:0]       count_reg,  count_next;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;

    assign dig_a = sa_reg[WIDTH-1 -: DIGIT];
    assign dig_b = sb_reg[WIDTH-1 -: DIGIT];

    // Flipping the sign bit maps two's complement onto an unsigned order.
    assign load_a = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
    assign load_b = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            cnt_reg   <= '0;
            gt_reg    <= 1'b0;
            eq_reg    <= 1'b0;
            lt_reg    <= 1'b0;
            count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            cnt_reg   <= cnt_next;
            gt_reg    <= gt_next;
            eq_reg    <= eq_next;
            lt_reg    <= lt_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        cnt_next   = cnt_reg;
        gt_next    = gt_reg;
        eq_next    = eq_reg;
        lt_next    = lt_reg;
        count_next = count_reg;

        if (bus.ena) begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sa_next    = load_a;
                        sb_next    = load_b;
                        cnt_next   = '0;
                        state_next = CMP;
                    end else if (state_reg == DONE) begin
                        state_next = IDLE;
                    end
                end
                CMP: begin
                    if (dig_a != dig_b) begin
                        gt_next    = (dig_a > dig_b);
                        lt_next    = (dig_a < dig_b);
                        eq_next    = 1'b0;
                        count_next = count_reg + 8'd1;
                        state_next = DONE;
                    end else if (cnt_reg == LAST_DIG) begin
                        gt_next    = 1'b0;
                        lt_next    = 1'b0;
                        eq_next    = 1'b1;
                        count_next = count_reg + 8'd1;
                        state_next = DONE;
                    end else begin
                        sa_next  = sa_reg << DIGIT;
                        sb_next  = sb_reg << DIGIT;
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_reg == CMP);
    assign bus.done      = (state_reg == DONE);
    assign bus.gt        = gt_reg;
    assign bus.eq        = eq_reg;
    assign bus.lt        = lt_reg;
    assign bus.cmp_count = count_reg;
endmodule

// File: tb/tb_bmsce_serial_comparator.sv
// Randomised and directed bench for the serial comparator: an arithmetic
// reference model is checked against the outputs on every falling edge.
module tb_bmsce_serial_comparator;
    logic clk;
    logic rst_n;

    bmsce_serial_comparator_if #(.WIDTH(8)) bus  ();
    bmsce_serial_comparator_if #(.WIDTH(2)) bus2 ();

    bmsce_serial_comparator #(.WIDTH(8), .DIGIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bmsce_serial_comparator #(.WIDTH(2), .DIGIT(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    logic chk_en = 1'b0;

    // Reference: result from plain integer compare, latency from the
    // position of the most significant differing 2-bit digit.
    function automatic logic [2:0] res_of(input logic [7:0] x, input logic [7:0] y, input logic sm);
        int xi;
        int yi;
        xi = sm ? int'($signed(x)) : int'(x);
        yi = sm ? int'($signed(y)) : int'(y);
        return {xi > yi, xi == yi, xi < yi};
    endfunction

    function automatic int lat_of(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        d = x ^ y;
        for (int i = 0; i < 4; i++)
            if (d[7-2*i -: 2] != 2'b00) return i + 1;
        return 4;
    endfunction

    logic       m_busy, m_done;
    logic [2:0] m_res, p_res;
    logic [7:0] m_cnt;
    int         m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= 3'b000;
            p_res  <= 3'b000;
            m_cnt  <= 8'd0;
            m_left <= 0;
        end else if (bus.ena) begin
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= p_res;
                    m_cnt  <= m_cnt + 8'd1;
                end
                m_left <= m_left - 1;
            end else begin
                m_done <= 1'b0;
                if (bus.start) begin
                    m_busy <= 1'b1;
                    m_left <= lat_of(bus.a, bus.b);
                    p_res  <= res_of(bus.a, bus.b, bus.signed_mode);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic [7:0] ta, input logic [7:0] tbv, input logic sm,
                           input int mode, input logic [2:0] exp_res, input int exp_lat,
                           input string name);
        int   cyc;
        logic seen;
        bus.a = ta; bus.b = tbv; bus.signed_mode = sm; bus.start = 1'b1; bus.ena = 1'b1;
        cyc  = -1;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 0) bus.start = 1'b0;
            if (mode == 1 && cyc == 1) bus.ena = 1'b0;
            if (mode == 1 && cyc == 4) bus.ena = 1'b1;
            if (mode == 2 && cyc == 1) begin
                bus.start = 1'b1; bus.a = ~ta; bus.signed_mode = ~sm;
            end
            if (mode == 2 && cyc == 2) bus.start = 1'b0;
            seen = bus.done;
        end
        if (!seen) begin
            n_vec++; n_miss++;
            $display("FAIL %s_timeout: got no done, required done within 40 cycles", name);
        end
        chk({name, "_res"}, int'({bus.gt, bus.eq, bus.lt}), int'(exp_res));
        chk({name, "_lat"}, cyc, exp_lat);
        $display("txn %s a=%02h b=%02h sm=%0d res=%03b lat=%0d cnt=%0d",
                 name, ta, tbv, sm, {bus.gt, bus.eq, bus.lt}, cyc, bus.cmp_count);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        int         cyc;
        logic       seen;

        rst_n = 1'b0;
        bus.ena = 1'b0; bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
        bus2.ena = 1'b1; bus2.start = 1'b0; bus2.signed_mode = 1'b0; bus2.a = '0; bus2.b = '0;

        // Per-cycle compare against the reference model.
        fork
            forever begin
                @(negedge clk);
                if (chk_en)
                    chk("cycle", int'({bus.busy, bus.done, bus.gt, bus.eq, bus.lt, bus.cmp_count}),
                        int'({m_busy, m_done, m_res, m_cnt}));
            end
        join_none

        repeat (2) @(negedge clk);
        chk("reset_state", int'({bus.busy, bus.done, bus.gt, bus.eq, bus.lt, bus.cmp_count}), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Hand-computed expectations.
        run_txn(8'hC3, 8'h3C, 1'b0, 0, 3'b100, 1, "unsigned_early");
        chk("count_first", int'(bus.cmp_count), 1);
        @(negedge clk);
        run_txn(8'h5A, 8'h5A, 1'b0, 0, 3'b010, 4, "equal");
        run_txn(8'h12, 8'h13, 1'b0, 0, 3'b001, 4, "last_digit_b2b");
        run_txn(8'h80, 8'h7F, 1'b1, 0, 3'b001, 1, "signed_80_7f");
        run_txn(8'h80, 8'h7F, 1'b0, 0, 3'b100, 1, "unsigned_80_7f");
        run_txn(8'hFF, 8'h01, 1'b1, 0, 3'b001, 1, "signed_ff_01");
        @(negedge clk);
        run_txn(8'h5A, 8'h5A, 1'b0, 2, 3'b010, 4, "start_in_cmp");
        @(negedge clk);
        run_txn(8'h5A, 8'h5A, 1'b0, 1, 3'b010, 7, "ena_drop");
        run_txn(8'h12, 8'h13, 1'b0, 1, 3'b001, 7, "ena_drop_lt");

        // Asynchronous reset mid-comparison, between clock edges.
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h5A; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async", int'({bus.busy, bus.done, bus.gt, bus.eq, bus.lt, bus.cmp_count}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_idle", int'({bus.busy, bus.done}), 0);

        // 257 completed comparisons wrap the count to 1.
        for (int k = 0; k < 257; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            rs = 1'($urandom);
            run_txn(ra, rb, rs, 0, res_of(ra, rb, rs), lat_of(ra, rb), "wrap_run");
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        chk("count_wrap", int'(bus.cmp_count), 1);

        // Free-running random stimulus; the per-cycle compare does the checking.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            bus.ena         = ($urandom_range(0, 3) != 0);
            bus.start       = ($urandom_range(0, 2) == 0);
            bus.signed_mode = 1'($urandom);
            bus.a           = 8'($urandom);
            bus.b           = ($urandom_range(0, 3) == 0) ? {bus.a[7:2], 2'($urandom)} : 8'($urandom);
        end
        @(negedge clk);
        bus.ena = 1'b1; bus.start = 1'b0;
        repeat (6) @(negedge clk);

        // WIDTH=2, DIGIT=1 exhaustive.
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                @(negedge clk);
                bus2.a = 2'(x); bus2.b = 2'(y); bus2.start = 1'b1;
                cyc = -1; seen = 1'b0;
                while (!seen && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc == 0) bus2.start = 1'b0;
                    seen = bus2.done;
                end
                chk("w2_res", int'({bus2.gt, bus2.eq, bus2.lt}), int'({x > y, x == y, x < y}));
                chk("w2_lat", cyc, (bus2.a[1] != bus2.b[1]) ? 1 : 2);
                $display("txn w2 a=%0d b=%0d res=%03b lat=%0d", x, y, {bus2.gt, bus2.eq, bus2.lt}, cyc);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
